mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Parametrised arbiter and sequencer for the single memory handshake (enable, rw, address, mfc). It replaces the OR-combining of per-FSM enable/rw lines. N requesters (fetch, load, store, future DMA) each present a request with address and write data. One winner is selected by fixed-priority or round-robin arbitration. The block owns the memory port for the whole transaction, waits for mfc and returns read data plus a done/err pulse to the winner.

Parameters:
N, 3, number of requesters (2..8)
DW, 16, data width
AW, 16, address width
RR, 0, arbitration mode: 0 = fixed priority (index 0 highest), 1 = round-robin
TIMEOUT, 255, cycles waiting for mfc before abort; 0 = no timeout
CW, 8, timeout counter width; must satisfy TIMEOUT < 2^CW

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
req  in  N  per-requester request level
req_rw  in  N  per-requester direction: 1 = write, 0 = read
req_addr  in  N*AW  packed addresses; requester i uses bits [i*AW +: AW]
req_wdata  in  N*DW  packed write data; requester i uses bits [i*DW +: DW]
gnt  out  N  one-hot; high for the whole transaction of the winner
done  out  N  one-cycle completion pulse to the winner
err  out  N  one-cycle pulse coincident with done; transaction timed out
rdata  out  DW  read data, valid in the done cycle, held until the next read completes
enable  out  1  memory enable
rw  out  1  memory direction, 1 = write
address  out  AW  memory address
memoryOut  out  DW  memory write data
memoryIn  in  DW  memory read data
mfc  in  1  memory function complete

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - gnt, done, err, enable, rw = 0; address, memoryOut, rdata = 0.
  - Round-robin pointer = 0; timeout counter = 0.
  - Applies immediately, including mid-transaction. Any in-flight transaction is dropped with no done pulse.
- Three states: IDLE, BUSY, DONE.
- IDLE:
  - If any req bit is set at the clock edge, choose a winner w.
    - RR = 0: lowest set index.
    - RR = 1: first set index at or after the pointer, wrapping modulo N.
  - Latch req_rw[w], req_addr[w] and req_wdata[w] into the memory outputs.
  - Set gnt[w] = 1 and enable = 1, then go to BUSY.
  - RR = 1: pointer <= (w + 1) mod N.
  - With no request, stay in IDLE with outputs unchanged and enable = 0.
- Latency: the first memory-visible cycle (enable = 1) is the cycle after req is sampled high.
- BUSY:
  - enable, rw, address, memoryOut and gnt are held stable; the counter increments each cycle.
  - If mfc = 1 at the edge: for a read, capture memoryIn into rdata. Then enable <= 0, done[w] <= 1, go to DONE.
  - Otherwise, if TIMEOUT != 0 and the counter reaches TIMEOUT - 1: enable <= 0, done[w] <= 1, err[w] <= 1, go to DONE. rdata is unchanged on timeout.
  - Changes to req or any req_* input during BUSY are ignored. The transaction always completes or times out.
- DONE (exactly one cycle):
  - done/err pulse visible; gnt still high.
  - Next edge: gnt, done, err <= 0; counter <= 0; go to IDLE.
  - No request can be granted in DONE, so there is at least one idle cycle of enable = 0 between transactions.
- Requester contract: drop req on seeing done. A req still high when the block is back in IDLE is treated as a new request.
- mfc is ignored in IDLE and DONE. A stray mfc never produces done.
- Write cycles leave rdata unchanged.
- Fixed priority can starve high indices by design. Round-robin guarantees service within N transactions.

Test Plan:
- Single read: req = 001, addr0 = 0x0040, mfc after 3 BUSY cycles with memoryIn = 0xBEEF -> enable high for 3 cycles at address 0x0040 with rw = 0; done = 001 one cycle; rdata = 0xBEEF; err = 000.
- Fixed priority, RR = 0: req = 110 held, each requester drops req after its done -> grant order 1 then 2; done pulses in that order; no overlap of enable.
- Round-robin, RR = 1, N = 3: req = 111 held continuously, mfc = 1 immediately each BUSY -> gnt sequence 001, 010, 100, 001; one idle cycle between transactions.
- Write then timeout, TIMEOUT = 4: requester 2 writes 0x1234 to 0x00FF, mfc never asserted -> enable high 4 cycles; done = 100 and err = 100 together; rdata unchanged; back in IDLE the cycle after.
- Mid-transaction input changes: requester 0 changes req_addr and drops req while in BUSY -> address and memoryOut stay at the latched values; done still pulses on mfc.
- Async reset: assert rst = 0 during BUSY between clock edges -> enable, gnt, rw, address = 0 before the next edge; no done. After rst = 1, a pending req is granted normally and the RR pointer restarts at 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates N requesters onto the single memory handshake
//               (enable/rw/address/mfc). It owns the port for a whole
//               transaction, waits for mfc (or times out) and returns read
//               data with a done/err pulse to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int N       = 3,
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int RR      = 0,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_rw,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [N-1:0]    err,
    output logic [DW-1:0]   rdata,
    output logic            enable,
    output logic            rw,
    output logic [AW-1:0]   address,
    output logic [DW-1:0]   memoryOut,
    input  logic [DW-1:0]   memoryIn,
    input  logic            mfc
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Counter value on which the last permitted BUSY cycle ends; only used
    // when a timeout is configured.
    localparam logic [CW-1:0] c_last_cnt = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [N-1:0]    gnt_q,     gnt_d;
    logic [N-1:0]    done_q,    done_d;
    logic [N-1:0]    err_q,     err_d;
    logic            enable_q,  enable_d;
    logic            rw_q,      rw_d;
    logic [AW-1:0]   address_q, address_d;
    logic [DW-1:0]   wdata_q,   wdata_d;
    logic [DW-1:0]   rdata_q,   rdata_d;
    logic [IW-1:0]   ptr_q,     ptr_d;
    logic [IW-1:0]   win_q,     win_d;
    logic [CW-1:0]   cnt_q,     cnt_d;

    logic            any_req;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   ptr_next;
    int              idx;

    // Select the winner: lowest set index, or first set index at/after the
    // round-robin pointer (wrapping) when RR mode is enabled.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (RR != 0) ? int'(ptr_q) + k : k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = IW'(idx);
            end
        end
    end

    // Pointer moves to the slot just after the winner, modulo N.
    always_comb begin
        ptr_next = (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
    end

    // Next-state and output logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        err_d     = err_q;
        enable_d  = enable_q;
        rw_d      = rw_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                enable_d = 1'b0;
                if (any_req) begin
                    win_d        = pick;
                    gnt_d        = '0;
                    gnt_d[pick]  = 1'b1;
                    enable_d     = 1'b1;
                    rw_d         = req_rw[pick];
                    address_d    = req_addr[pick*AW +: AW];
                    wdata_d      = req_wdata[pick*DW +: DW];
                    cnt_d        = '0;
                    if (RR != 0) begin
                        ptr_d = ptr_next;
                    end
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mfc) begin
                    if (!rw_q) begin
                        rdata_d = memoryIn;
                    end
                    enable_d      = 1'b0;
                    done_d        = '0;
                    done_d[win_q] = 1'b1;
                    state_d       = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == c_last_cnt)) begin
                    // Abort: rdata deliberately left untouched.
                    enable_d      = 1'b0;
                    done_d        = '0;
                    done_d[win_q] = 1'b1;
                    err_d         = '0;
                    err_d[win_q]  = 1'b1;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                // Single pulse cycle; no grant here guarantees an idle gap.
                gnt_d   = '0;
                done_d  = '0;
                err_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; asynchronous reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            enable_q  <= 1'b0;
            rw_q      <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            enable_q  <= enable_d;
            rw_q      <= rw_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign enable    = enable_q;
    assign rw        = rw_q;
    assign address   = address_q;
    assign memoryOut = wdata_q;
    assign rdata     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter. Instance 0 uses fixed
//               priority, instance 1 round-robin, both with a 4-cycle
//               timeout. A transaction-level model is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;
    localparam int CW = 8;

    logic clk;
    logic rst;

    logic [N-1:0]    req_v   [2];
    logic [N-1:0]    rw_v    [2];
    logic [N*AW-1:0] addr_v  [2];
    logic [N*DW-1:0] wd_v    [2];
    logic [DW-1:0]   memin_v [2];
    logic            mfc_v   [2];

    logic [N-1:0]    gnt_o   [2];
    logic [N-1:0]    done_o  [2];
    logic [N-1:0]    err_o   [2];
    logic [DW-1:0]   rdata_o [2];
    logic            en_o    [2];
    logic            rwo_o   [2];
    logic [AW-1:0]   addr_o  [2];
    logic [DW-1:0]   mout_o  [2];

    int checks   = 0;
    int failures = 0;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            mem_port_arbiter #(
                .N(N), .DW(DW), .AW(AW), .RR(g), .TIMEOUT(TO), .CW(CW)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .req       (req_v[g]),
                .req_rw    (rw_v[g]),
                .req_addr  (addr_v[g]),
                .req_wdata (wd_v[g]),
                .gnt       (gnt_o[g]),
                .done      (done_o[g]),
                .err       (err_o[g]),
                .rdata     (rdata_o[g]),
                .enable    (en_o[g]),
                .rw        (rwo_o[g]),
                .address   (addr_o[g]),
                .memoryOut (mout_o[g]),
                .memoryIn  (memin_v[g]),
                .mfc       (mfc_v[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit            m_active [2];   // memory port owned, waiting for mfc
    bit            m_finish [2];   // completion pulse cycle
    bit            m_to     [2];
    int            m_owner  [2];
    int            m_age    [2];   // BUSY cycles already elapsed
    int            m_last   [2];   // most recent RR winner
    logic          m_rw     [2];
    logic [AW-1:0] m_addr   [2];
    logic [DW-1:0] m_wd     [2];
    logic [DW-1:0] m_rd     [2];

    function automatic int pickw(input int inst);
        int c;
        if (inst == 0) begin
            for (int k = 0; k < N; k++) if (req_v[inst][k]) return k;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last[inst] + k) % N;
                if (req_v[inst][c]) return c;
            end
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_active[i] <= 1'b0;
                m_finish[i] <= 1'b0;
                m_to[i]     <= 1'b0;
                m_owner[i]  <= 0;
                m_age[i]    <= 0;
                m_last[i]   <= N - 1;
                m_rw[i]     <= 1'b0;
                m_addr[i]   <= '0;
                m_wd[i]     <= '0;
                m_rd[i]     <= '0;
            end else if (m_finish[i]) begin
                m_finish[i] <= 1'b0;
                m_to[i]     <= 1'b0;
            end else if (m_active[i]) begin
                m_age[i] <= m_age[i] + 1;
                if (mfc_v[i]) begin
                    if (!m_rw[i]) m_rd[i] <= memin_v[i];
                    m_active[i] <= 1'b0;
                    m_finish[i] <= 1'b1;
                end else if (m_age[i] + 1 >= TO) begin
                    m_active[i] <= 1'b0;
                    m_finish[i] <= 1'b1;
                    m_to[i]     <= 1'b1;
                end
            end else if (req_v[i] != '0) begin
                m_active[i] <= 1'b1;
                m_age[i]    <= 0;
                m_owner[i]  <= pickw(i);
                m_last[i]   <= pickw(i);
                m_rw[i]     <= rw_v[i][pickw(i)];
                m_addr[i]   <= addr_v[i][pickw(i)*AW +: AW];
                m_wd[i]     <= wd_v[i][pickw(i)*DW +: DW];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    logic [N-1:0] e_gnt, e_done, e_err;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_gnt  = (m_active[i] || m_finish[i]) ? N'(1 << m_owner[i]) : '0;
            e_done = m_finish[i] ? N'(1 << m_owner[i]) : '0;
            e_err  = (m_finish[i] && m_to[i]) ? N'(1 << m_owner[i]) : '0;
            chk("gnt",     i, 64'(gnt_o[i]),   64'(e_gnt));
            chk("done",    i, 64'(done_o[i]),  64'(e_done));
            chk("err",     i, 64'(err_o[i]),   64'(e_err));
            chk("enable",  i, 64'(en_o[i]),    64'(m_active[i]));
            chk("rw",      i, 64'(rwo_o[i]),   64'(m_rw[i]));
            chk("address", i, 64'(addr_o[i]),  64'(m_addr[i]));
            chk("memOut",  i, 64'(mout_o[i]),  64'(m_wd[i]));
            chk("rdata",   i, 64'(rdata_o[i]), 64'(m_rd[i]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] seq [4];

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = '0; rw_v[i] = '0; addr_v[i] = '0; wd_v[i] = '0;
            memin_v[i] = '0; mfc_v[i] = 1'b0;
        end
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
        tick(); tick();
        chk("rst_gnt",   0, 64'(gnt_o[0]),   64'h0);
        chk("rst_en",    0, 64'(en_o[0]),    64'h0);
        chk("rst_rdata", 0, 64'(rdata_o[0]), 64'h0);
        rst = 1'b1;
        tick();

        // Single read, mfc on the third BUSY cycle.
        addr_v[0][0*AW +: AW] = 16'h0040;
        req_v[0] = 3'b001;
        tick();
        chk("t1_gnt",  0, 64'(gnt_o[0]),  64'h1);
        chk("t1_addr", 0, 64'(addr_o[0]), 64'h0040);
        chk("t1_en1",  0, 64'(en_o[0]),   64'h1);
        tick(); chk("t1_en2", 0, 64'(en_o[0]), 64'h1);
        tick(); chk("t1_en3", 0, 64'(en_o[0]), 64'h1);
        memin_v[0] = 16'hBEEF; mfc_v[0] = 1'b1;
        tick();
        chk("t1_done",  0, 64'(done_o[0]),  64'h1);
        chk("t1_err",   0, 64'(err_o[0]),   64'h0);
        chk("t1_rdata", 0, 64'(rdata_o[0]), 64'hBEEF);
        chk("t1_en_off",0, 64'(en_o[0]),    64'h0);
        req_v[0] = '0; mfc_v[0] = 1'b0;
        tick();
        chk("t1_idle", 0, 64'(gnt_o[0]), 64'h0);

        // Fixed priority: 1 before 2.
        addr_v[0][1*AW +: AW] = 16'h0100;
        addr_v[0][2*AW +: AW] = 16'h0200;
        req_v[0] = 3'b110;
        tick();
        chk("t2_gnt1", 0, 64'(gnt_o[0]), 64'h2);
        memin_v[0] = 16'h1111; mfc_v[0] = 1'b1;
        tick();
        chk("t2_done1", 0, 64'(done_o[0]), 64'h2);
        req_v[0] = 3'b100; mfc_v[0] = 1'b0;
        tick();
        chk("t2_gap", 0, 64'(en_o[0]), 64'h0);
        tick();
        chk("t2_gnt2", 0, 64'(gnt_o[0]),  64'h4);
        chk("t2_adr2", 0, 64'(addr_o[0]), 64'h0200);
        memin_v[0] = 16'h2222; mfc_v[0] = 1'b1;
        tick();
        chk("t2_done2", 0, 64'(done_o[0]),  64'h4);
        chk("t2_rdata", 0, 64'(rdata_o[0]), 64'h2222);
        req_v[0] = '0; mfc_v[0] = 1'b0;
        tick();

        // Round-robin with all requesters held and mfc always high.
        addr_v[1] = {16'h0030, 16'h0020, 16'h0010};
        req_v[1] = 3'b111; mfc_v[1] = 1'b1; memin_v[1] = 16'h3333;
        for (int k = 0; k < 4; k++) begin
            tick(); chk("t3_gnt",  1, 64'(gnt_o[1]),  64'(seq[k]));
            tick(); chk("t3_done", 1, 64'(done_o[1]), 64'(seq[k]));
            tick(); chk("t3_idle", 1, 64'(en_o[1]),   64'h0);
        end
        req_v[1] = '0; mfc_v[1] = 1'b0;
        tick();

        // Write with no mfc: timeout after 4 enable cycles.
        rw_v[0] = 3'b100;
        addr_v[0][2*AW +: AW] = 16'h00FF;
        wd_v[0][2*DW +: DW]   = 16'h1234;
        req_v[0] = 3'b100;
        tick();
        chk("t4_gnt",  0, 64'(gnt_o[0]),  64'h4);
        chk("t4_rw",   0, 64'(rwo_o[0]),  64'h1);
        chk("t4_mout", 0, 64'(mout_o[0]), 64'h1234);
        tick(); tick(); tick();
        chk("t4_en4", 0, 64'(en_o[0]), 64'h1);
        tick();
        chk("t4_done",  0, 64'(done_o[0]),  64'h4);
        chk("t4_err",   0, 64'(err_o[0]),   64'h4);
        chk("t4_rdata", 0, 64'(rdata_o[0]), 64'h2222);
        chk("t4_en_off",0, 64'(en_o[0]),    64'h0);
        req_v[0] = '0;
        tick();
        chk("t4_idle_gnt", 0, 64'(gnt_o[0]), 64'h0);
        chk("t4_idle_err", 0, 64'(err_o[0]), 64'h0);

        // Inputs changing during BUSY are ignored.
        rw_v[0] = 3'b001;
        addr_v[0][0*AW +: AW] = 16'h0A0A;
        wd_v[0][0*DW +: DW]   = 16'h5555;
        req_v[0] = 3'b001;
        tick();
        addr_v[0][0*AW +: AW] = 16'h0B0B;
        wd_v[0][0*DW +: DW]   = 16'h6666;
        rw_v[0] = 3'b000; req_v[0] = 3'b000;
        tick();
        chk("t5_addr", 0, 64'(addr_o[0]), 64'h0A0A);
        chk("t5_mout", 0, 64'(mout_o[0]), 64'h5555);
        chk("t5_rw",   0, 64'(rwo_o[0]),  64'h1);
        memin_v[0] = 16'h7777; mfc_v[0] = 1'b1;
        tick();
        chk("t5_done",  0, 64'(done_o[0]),  64'h1);
        chk("t5_rdata", 0, 64'(rdata_o[0]), 64'h2222);
        mfc_v[0] = 1'b0;
        tick();

        // Asynchronous reset during BUSY on the round-robin instance.
        rw_v[1] = 3'b010;
        req_v[1] = 3'b010;
        tick();
        chk("t6_gnt", 1, 64'(gnt_o[1]), 64'h2);
        #2 rst = 1'b0;
        #1;
        chk("t6_en",   1, 64'(en_o[1]),   64'h0);
        chk("t6_gnt0", 1, 64'(gnt_o[1]),  64'h0);
        chk("t6_rw",   1, 64'(rwo_o[1]),  64'h0);
        chk("t6_addr", 1, 64'(addr_o[1]), 64'h0);
        req_v[1] = 3'b111;
        tick();
        chk("t6_nodone", 1, 64'(done_o[1]), 64'h0);
        rst = 1'b1;
        tick();
        chk("t6_ptr0",  1, 64'(gnt_o[1]),  64'h1);
        chk("t6_addr0", 1, 64'(addr_o[1]), 64'h0010);
        mfc_v[1] = 1'b1;
        tick();
        chk("t6_done", 1, 64'(done_o[1]), 64'h1);
        req_v[1] = '0; mfc_v[1] = 1'b0;
        tick();

        // Stray mfc while idle must not produce done.
        mfc_v[0] = 1'b1;
        tick(); tick();
        chk("t7_stray", 0, 64'(done_o[0]), 64'h0);
        mfc_v[0] = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
